// File: rtl/seg_scan_pkg.sv
// Shared types and constants for the multiplexed 7-segment scan/capture block.
package seg_scan_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    BLANK,
    PRESENT
  } state_t;

  localparam logic [6:0] SEG_BLANK   = 7'b1111111;
  localparam logic [3:0] BCD_INVALID = 4'hF;
  localparam logic [3:0] BCD_MAX     = 4'd9;

endpackage

// File: rtl/seven_segment_to_bcd.sv
// Decodes an active-low a..g segment pattern (MSB = a) into BCD; any other
// pattern, including all segments off, yields BCD_INVALID.
module seven_segment_to_bcd
  import seg_scan_pkg::*;
(
  input  logic [6:0] seg_n,
  output logic [3:0] bcd
);

  always_comb begin
    bcd = BCD_INVALID;
    case (seg_n)
      7'b0000001: bcd = 4'd0;
      7'b1001111: bcd = 4'd1;
      7'b0010010: bcd = 4'd2;
      7'b0000110: bcd = 4'd3;
      7'b1001100: bcd = 4'd4;
      7'b0100100: bcd = 4'd5;
      7'b0100000: bcd = 4'd6;
      7'b0001111: bcd = 4'd7;
      7'b0000000: bcd = 4'd8;
      7'b0000100: bcd = 4'd9;
      default:    bcd = BCD_INVALID;
    endcase
  end

endmodule

// File: rtl/seg_scan_capture.sv
// Scans a common-anode multiplexed 7-segment display one digit at a time,
// decodes each settled digit and presents the packed frame on valid/ready.
module seg_scan_capture
  import seg_scan_pkg::*;
#(
  parameter int unsigned NUM_DIGITS    = 4,
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    scan_en,
  input  logic [6:0]              seg_in,
  output logic [NUM_DIGITS-1:0]   dig_en_n,
  output logic                    busy,
  output logic [4*NUM_DIGITS-1:0] frame_bcd,
  output logic [NUM_DIGITS-1:0]   frame_err,
  output logic                    frame_valid,
  input  logic                    frame_ready
);

  localparam int unsigned DIG_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [DIG_W-1:0] LAST_DIGIT = DIG_W'(NUM_DIGITS - 1);
  localparam logic [CNT_W-1:0] LAST_CNT   = CNT_W'(SETTLE_CYCLES - 1);

  state_t                  state, state_d;
  logic [DIG_W-1:0]        digit, digit_d;
  logic [CNT_W-1:0]        cnt, cnt_d;
  logic [6:0]              seg_meta, seg_sync;
  logic [3:0]              dec_bcd;
  logic                    capture_c;
  logic                    consume_c;
  logic [NUM_DIGITS-1:0]   dig_en_d;
  logic [4*NUM_DIGITS-1:0] bcd_d;
  logic [NUM_DIGITS-1:0]   err_d;
  logic                    valid_d;

  // Two-flop synchronizer for the asynchronous segment bus
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_meta <= SEG_BLANK;
      seg_sync <= SEG_BLANK;
    end else begin
      seg_meta <= seg_in;
      seg_sync <= seg_meta;
    end
  end

  seven_segment_to_bcd u_dec (
    .seg_n (seg_sync),
    .bcd   (dec_bcd)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Next state plus next values of every registered output
  always_comb begin
    state_d   = state;
    digit_d   = digit;
    cnt_d     = cnt;
    capture_c = 1'b0;
    consume_c = frame_valid && frame_ready;
    dig_en_d  = '1;
    bcd_d     = frame_bcd;
    err_d     = frame_err;
    valid_d   = 1'b0;

    case (state)
      IDLE: begin
        if (scan_en) begin
          state_d = DRIVE;
          digit_d = '0;
          cnt_d   = '0;
        end
      end
      DRIVE: begin
        if (cnt == LAST_CNT) begin
          capture_c = 1'b1;
          state_d   = BLANK;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      BLANK: begin
        if (digit == LAST_DIGIT) begin
          state_d = PRESENT;
        end else begin
          digit_d = digit + DIG_W'(1);
          cnt_d   = '0;
          state_d = DRIVE;
        end
      end
      PRESENT: begin
        if (consume_c) begin
          digit_d = '0;
          cnt_d   = '0;
          state_d = scan_en ? DRIVE : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Valid follows PRESENT by one cycle and drops on the accepting edge
    valid_d = (state == PRESENT) && !consume_c;

    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (state_d == DRIVE && digit_d == DIG_W'(i)) begin
        dig_en_d[i] = 1'b0;
      end
      if (capture_c && digit == DIG_W'(i)) begin
        bcd_d[4*i +: 4] = dec_bcd;
        err_d[i]        = (dec_bcd > BCD_MAX);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit       <= '0;
      cnt         <= '0;
      dig_en_n    <= '1;
      busy        <= 1'b0;
      frame_bcd   <= '0;
      frame_err   <= '0;
      frame_valid <= 1'b0;
    end else begin
      digit       <= digit_d;
      cnt         <= cnt_d;
      dig_en_n    <= dig_en_d;
      busy        <= (state_d != IDLE);
      frame_bcd   <= bcd_d;
      frame_err   <= err_d;
      frame_valid <= valid_d;
    end
  end

endmodule

// File: tb/tb_seg_scan_capture.sv
// Self-checking bench for seg_scan_capture: models the multiplexed display and
// checks frames against a scoreboard of expected frames.
module tb_seg_scan_capture;
  import seg_scan_pkg::*;

  localparam int unsigned ND = 4;
  localparam int unsigned SC = 4;

  typedef struct packed {
    logic [4*ND-1:0] bcd;
    logic [ND-1:0]   err;
  } frame_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            scan_en = 1'b0;
  logic            frame_ready = 1'b0;
  logic [6:0]      seg_in;
  logic [ND-1:0]   dig_en_n;
  logic            busy;
  logic [4*ND-1:0] frame_bcd;
  logic [ND-1:0]   frame_err;
  logic            frame_valid;
  logic [6:0]      disp [ND];
  frame_t          exp_q [$];
  int              checks = 0;
  int              errors = 0;

  always #5 clk = ~clk;

  seg_scan_capture #(.NUM_DIGITS(ND), .SETTLE_CYCLES(SC)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .scan_en     (scan_en),
    .seg_in      (seg_in),
    .dig_en_n    (dig_en_n),
    .busy        (busy),
    .frame_bcd   (frame_bcd),
    .frame_err   (frame_err),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready)
  );

  // Display model: the digit whose enable is low drives the bus
  always_comb begin
    seg_in = SEG_BLANK;
    for (int i = 0; i < ND; i++) begin
      if (!dig_en_n[i]) seg_in = disp[i];
    end
  end

  function automatic logic [6:0] seg_of(input int d);
    logic [6:0] hi;
    case (d)
      0: hi = 7'b1111110;
      1: hi = 7'b0110000;
      2: hi = 7'b1101101;
      3: hi = 7'b1111001;
      4: hi = 7'b0110011;
      5: hi = 7'b1011011;
      6: hi = 7'b1011111;
      7: hi = 7'b1110000;
      8: hi = 7'b1111111;
      9: hi = 7'b1111011;
      10: hi = 7'b0000001;
      default: hi = 7'b0000000;
    endcase
    return ~hi;
  endfunction

  function automatic frame_t expect_frame();
    frame_t f;
    logic [3:0] nib;
    f = '0;
    for (int i = 0; i < ND; i++) begin
      nib = 4'hF;
      for (int d = 0; d < 10; d++) begin
        if (disp[i] == seg_of(d)) nib = 4'(d);
      end
      f.bcd[4*i +: 4] = nib;
      f.err[i] = (nib > 4'd9);
    end
    return f;
  endfunction

  // Codes: 0..9 digit, 10 lone g segment (dash), -1 blank
  task automatic set_disp(input int d3, input int d2, input int d1, input int d0);
    int v [ND];
    v[0] = d0; v[1] = d1; v[2] = d2; v[3] = d3;
    for (int i = 0; i < ND; i++) disp[i] = (v[i] < 0) ? SEG_BLANK : seg_of(v[i]);
  endtask

  task automatic start_scan();
    @(negedge clk);
    scan_en = 1'b1;
    exp_q.push_back(expect_frame());
    @(negedge clk);
  endtask

  task automatic wait_valid(input string name, output int cyc);
    cyc = 0;
    while (!frame_valid && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (!frame_valid) begin
      errors++;
      $display("FAIL %s timeout: frame_valid=%b required 1", name, frame_valid);
    end
  endtask

  task automatic check_frame(input string name);
    frame_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s scoreboard empty: frame_bcd=%h", name, frame_bcd);
    end else begin
      e = exp_q.pop_front();
      if (frame_bcd !== e.bcd) begin
        errors++;
        $display("FAIL %s bcd: got %h required %h", name, frame_bcd, e.bcd);
      end
      checks++;
      if (frame_err !== e.err) begin
        errors++;
        $display("FAIL %s err: got %b required %b", name, frame_err, e.err);
      end
    end
  endtask

  task automatic test_reset();
    set_disp(-1, -1, -1, -1);
    repeat (2) @(negedge clk);
    checks += 5;
    if (dig_en_n !== '1)  begin errors++; $display("FAIL reset dig_en_n: got %b required 1111", dig_en_n); end
    if (busy !== 1'b0)    begin errors++; $display("FAIL reset busy: got %b required 0", busy); end
    if (frame_valid !== 1'b0) begin errors++; $display("FAIL reset valid: got %b required 0", frame_valid); end
    if (frame_bcd !== '0) begin errors++; $display("FAIL reset bcd: got %h required 0000", frame_bcd); end
    if (frame_err !== '0) begin errors++; $display("FAIL reset err: got %b required 0000", frame_err); end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || dig_en_n !== '1) begin
      errors++;
      $display("FAIL idle_after_reset: busy=%b dig_en_n=%b required 0/1111", busy, dig_en_n);
    end
  endtask

  task automatic test_basic();
    int cyc;
    set_disp(1, 2, 3, 4);
    frame_ready = 1'b1;
    start_scan();
    scan_en = 1'b0;
    wait_valid("basic", cyc);
    checks++;
    if (cyc != 21) begin errors++; $display("FAIL basic latency: got %0d required 21", cyc); end
    checks++;
    if (frame_bcd !== 16'h1234) begin errors++; $display("FAIL basic bcd_const: got %h required 1234", frame_bcd); end
    check_frame("basic");
    @(negedge clk);
    checks++;
    if (frame_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL basic after_consume: valid=%b busy=%b required 0/0", frame_valid, busy);
    end
  endtask

  task automatic test_blank_digit();
    int cyc;
    set_disp(1, 2, -1, 4);
    start_scan();
    scan_en = 1'b0;
    wait_valid("blank", cyc);
    checks += 2;
    if (frame_bcd !== 16'h12F4) begin errors++; $display("FAIL blank bcd_const: got %h required 12f4", frame_bcd); end
    if (frame_err !== 4'b0010) begin errors++; $display("FAIL blank err_const: got %b required 0010", frame_err); end
    check_frame("blank");
    @(negedge clk);
  endtask

  task automatic test_stall();
    int cyc;
    frame_t e;
    set_disp(9, 8, 7, 6);
    e = expect_frame();
    frame_ready = 1'b0;
    start_scan();
    scan_en = 1'b0;
    wait_valid("stall", cyc);
    check_frame("stall");
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      checks++;
      if (frame_valid !== 1'b1 || frame_bcd !== e.bcd || frame_err !== e.err || dig_en_n !== '1) begin
        errors++;
        $display("FAIL stall hold%0d: valid=%b bcd=%h err=%b en=%b required 1/%h/%b/1111",
                 k, frame_valid, frame_bcd, frame_err, dig_en_n, e.bcd, e.err);
      end
    end
    frame_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (frame_valid !== 1'b0) begin errors++; $display("FAIL stall release: valid=%b required 0", frame_valid); end
  endtask

  task automatic test_back_to_back();
    int cyc, last, frames, drive_k, high_k;
    bit seq_ok;
    frame_ready = 1'b1;
    set_disp(5, 0, 9, 10);
    @(negedge clk);
    scan_en = 1'b1;
    exp_q.push_back(expect_frame());
    cyc = 0; last = 0; frames = 0; drive_k = 0; high_k = 0; seq_ok = 1'b1;
    while (frames < 3 && cyc < 300) begin
      @(negedge clk);
      cyc++;
      checks++;
      if ($countones(~dig_en_n) > 1) begin
        errors++;
        $display("FAIL b2b onehot: dig_en_n=%b at cycle %0d", dig_en_n, cyc);
      end
      if ($countones(~dig_en_n) == 1) begin
        if (dig_en_n !== ~(ND'(1) << (drive_k / SC))) seq_ok = 1'b0;
        drive_k++;
      end else begin
        high_k++;
      end
      if (frame_valid) begin
        checks += 4;
        if (cyc - last != 22) begin errors++; $display("FAIL b2b period: got %0d required 22", cyc - last); end
        if (drive_k != ND * SC) begin errors++; $display("FAIL b2b drive_cycles: got %0d required %0d", drive_k, ND * SC); end
        if (high_k != ND + 2) begin errors++; $display("FAIL b2b high_cycles: got %0d required %0d", high_k, ND + 2); end
        if (!seq_ok) begin errors++; $display("FAIL b2b digit_order: got out-of-order required 0..%0d", ND - 1); end
        check_frame("b2b");
        frames++;
        last = cyc; drive_k = 0; high_k = 0; seq_ok = 1'b1;
        if (frames == 1) begin set_disp(3, 6, 8, 1); exp_q.push_back(expect_frame()); end
        if (frames == 2) begin set_disp(7, 10, 2, 0); exp_q.push_back(expect_frame()); end
        if (frames == 3) scan_en = 1'b0;
      end
    end
    checks++;
    if (frames != 3) begin errors++; $display("FAIL b2b frame_count: got %0d required 3", frames); end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || frame_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b end_idle: busy=%b valid=%b required 0/0", busy, frame_valid);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    frame_ready = 1'b1;
    set_disp(1, 2, 3, 4);
    @(negedge clk);
    scan_en = 1'b1;
    @(negedge clk);
    scan_en = 1'b0;
    n = 0;
    while (dig_en_n[2] !== 1'b0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (dig_en_n[2] !== 1'b0) begin errors++; $display("FAIL rstmid reach_digit2: dig_en_n=%b required 1011", dig_en_n); end
    #2 rst_n = 1'b0;
    #1;
    checks += 5;
    if (dig_en_n !== '1)  begin errors++; $display("FAIL rstmid dig_en_n: got %b required 1111", dig_en_n); end
    if (busy !== 1'b0)    begin errors++; $display("FAIL rstmid busy: got %b required 0", busy); end
    if (frame_valid !== 1'b0) begin errors++; $display("FAIL rstmid valid: got %b required 0", frame_valid); end
    if (frame_bcd !== '0) begin errors++; $display("FAIL rstmid bcd: got %h required 0000", frame_bcd); end
    if (frame_err !== '0) begin errors++; $display("FAIL rstmid err: got %b required 0000", frame_err); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || dig_en_n !== '1 || frame_valid !== 1'b0) begin
        errors++;
        $display("FAIL rstmid idle%0d: busy=%b en=%b valid=%b required 0/1111/0", k, busy, dig_en_n, frame_valid);
      end
    end
  endtask

  task automatic test_drop_scan();
    int cyc;
    frame_ready = 1'b1;
    set_disp(8, 6, 0, 2);
    start_scan();
    repeat (5) @(negedge clk);
    scan_en = 1'b0;
    wait_valid("drop", cyc);
    checks++;
    if (cyc + 5 != 21) begin errors++; $display("FAIL drop latency: got %0d required 21", cyc + 5); end
    check_frame("drop");
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || frame_valid !== 1'b0) begin
        errors++;
        $display("FAIL drop idle%0d: busy=%b valid=%b required 0/0", k, busy, frame_valid);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_blank_digit();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    test_drop_scan();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard leftover: got %0d entries required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
